uart_tx_fifo: RTL

//  Parametrised UART transmitter with a buffering TX FIFO and a runtime frame format.
//  - Data bits selectable 5..8, stop bits 1 or 2, optional parity.
//  - Sits between the CPU peripheral bus (byte writes) and the TXD pin.
//  - Supersedes the fixed-format single-byte transmitter in the computer's UART.

---
 rtl/uart_tx_fifo.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a TX FIFO and a runtime frame format (5..8 data, 1/2 stop).
// Define UART_TX_PARITY_EN to build the optional parity bit; otherwise parity_mode is ignored.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  output logic                        txd,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        busy,
  output logic                        ovf,
  input  logic [DIV_W-1:0]            cycles_per_bit,
  input  logic [3:0]                  data_bits,
  input  logic                        stop2,
  input  logic [1:0]                  parity_mode
);
  localparam int AW = $clog2(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t state, state_nx;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push, pop, load;

  logic [DIV_W-1:0] cyc_cnt, sh_n_m1;
  logic [2:0]       bit_cnt, sh_db_last, db_last;
  logic [7:0]       shift;
  logic             sh_stop2;
  logic             bit_end;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign push  = wr_en && !full;
  assign pop   = load;
  assign busy  = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      ovf <= wr_en && full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Out-of-range data_bits clamp to 5..8; held as the index of the last data bit.
  always_comb begin
    if (data_bits < 4'd5)      db_last = 3'd4;
    else if (data_bits > 4'd8) db_last = 3'd7;
    else                       db_last = 3'(data_bits - 4'd1);
  end

  assign bit_end = (cyc_cnt == sh_n_m1);

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

`ifdef UART_TX_PARITY_EN
  logic sh_par_en, sh_par_odd, par;
`else
  logic unused_parity;
  assign unused_parity = ^parity_mode;
`endif

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_nx = START;
          load     = 1'b1;
        end
      end
      START: begin
        if (bit_end) state_nx = DATA;
      end
      DATA: begin
        if (bit_end && bit_cnt == sh_db_last) begin
`ifdef UART_TX_PARITY_EN
          state_nx = sh_par_en ? PARITY : STOP;
`else
          state_nx = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_nx = STOP;
      end
`endif
      STOP: begin
        // Chain straight into the next frame when more data is waiting.
        if (bit_end && (!sh_stop2 || bit_cnt[0])) begin
          if (!empty) begin
            state_nx = START;
            load     = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      txd        <= 1'b1;
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      sh_n_m1    <= '0;
      sh_db_last <= 3'd7;
      sh_stop2   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      sh_par_en  <= 1'b0;
      sh_par_odd <= 1'b0;
      par        <= 1'b0;
`endif
    end else begin
      case (state)
        START:   txd <= 1'b0;
        DATA:    txd <= shift[0];
`ifdef UART_TX_PARITY_EN
        PARITY:  txd <= par ^ sh_par_odd;
`endif
        default: txd <= 1'b1;
      endcase

      // Frame format is frozen at frame start; later config changes wait for the next frame.
      if (load) begin
        shift      <= mem[rd_ptr];
        sh_n_m1    <= (cycles_per_bit == '0) ? '0 : cycles_per_bit - 1'b1;
        sh_db_last <= db_last;
        sh_stop2   <= stop2;
        cyc_cnt    <= '0;
        bit_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
        sh_par_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        sh_par_odd <= (parity_mode == 2'b10);
        par        <= 1'b0;
`endif
      end else if (state != IDLE) begin
        if (bit_end) begin
          cyc_cnt <= '0;
          if (state == DATA) begin
            shift   <= shift >> 1;
            bit_cnt <= (bit_cnt == sh_db_last) ? 3'd0 : bit_cnt + 1'b1;
`ifdef UART_TX_PARITY_EN
            par     <= par ^ shift[0];
`endif
          end else if (state == STOP) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end else begin
          cyc_cnt <= cyc_cnt + 1'b1;
        end
      end
    end
  end

endmodule
